sn_operand_serializer: RTL and testbench
========================================

Name: sn_operand_serializer

Overview:
- Transmit-side counterpart of the core's serial operand deserializer.
- Accepts two 9-bit stochastic operands through a valid/ready handshake.
- Shifts both out in lockstep on two serial lines. Frame format: 9 data bits LSB-first, then guard bits.
- Used in the test harness and in the host-facing bridge to drive the core's operand input pins. Can repeat the held frame continuously so the receiver's offset capture always finds a valid frame.

Parameters:
- DATA_W, 9: operand width in bits.
- GUARD_BITS, 1: trailing buffer bits per frame. Minimum 1.
- IDLE_LEVEL, 1'b0: serial line level when no frame is active.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  serializer can accept a pair this cycle.
- in_data_1  in  DATA_W  operand 1 (drives line 1).
- in_data_2  in  DATA_W  operand 2 (drives line 2).
- repeat_en  in  1  when high, resend the held pair after each frame if no new pair is accepted.
- ser_out_1  out  1  serial line 1, registered.
- ser_out_2  out  1  serial line 2, registered.
- frame_start  out  1  high during the bit-0 cycle of every frame, registered.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; held registers = 0; held_vld = 0; bit_cnt = 0.
  - ser_out_1/2 = IDLE_LEVEL; frame_start = 0; busy = 0; in_ready = 1 after release.
- Accept occurs on a cycle where in_valid && in_ready. in_data_1/2 are captured into the held registers; held_vld is set.
- States:
  - IDLE: lines at IDLE_LEVEL; in_ready = 1.
    - On accept → DATA.
    - Else if repeat_en && held_vld → DATA, resending the held pair.
  - DATA: lasts DATA_W cycles. Cycle k (k = 0..DATA_W-1) drives held[k] on each line; frame_start = 1 only at k = 0. bit_cnt increments each cycle. After k = DATA_W-1 → GUARD.
  - GUARD: lasts GUARD_BITS cycles; each guard bit drives 0.
    - in_ready = 1 only in the final guard cycle.
    - At the end: on accept → DATA with the new pair. Else if repeat_en && held_vld → DATA with the held pair. Else → IDLE.
- Latency: accept in cycle N puts bit 0 on the lines and frame_start high in cycle N+1.
- Back-to-back frames have no gap. Frame period is DATA_W+GUARD_BITS cycles (10 by default).
- in_ready is 0 in DATA and in non-final GUARD cycles. in_data is ignored then; the held pair never changes mid-frame.
- in_valid may drop without acceptance; no state effect.
- repeat_en is sampled only at frame boundaries (IDLE or final guard cycle). Deasserting it mid-frame finishes the current frame, then goes IDLE.
- bit_cnt width is clog2(DATA_W+GUARD_BITS). It clears at every frame start and never wraps mid-frame.
- Reset mid-frame: lines return to IDLE_LEVEL immediately (asynchronously); held_vld clears; no partial frame resumes.
- busy = (state != IDLE).

Optional Feature:
- Macro: SN_SERIAL_PARITY_EN.
- Defined: the first guard bit on each line carries even parity of that line's DATA_W bits (XOR-reduce of the held value). Remaining guard bits stay 0.
- Undefined: all guard bits are 0, matching the core's dummy-bit format.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package holds:
  - SN_DATA_W = 9, SN_GUARD_BITS = 1, SN_FRAME_LEN = 10.
  - State enum {IDLE, DATA, GUARD}.
  - SN_SEED constant, reused by the core LFSR.
- One natural sub-module: sn_lane_shifter, instanced twice. It holds one held register and one output flop; the shared FSM and bit_cnt drive both instances.

Test Plan:
- Basic frame: reset, in_valid=1 with in_data_1=9'h1A5, in_data_2=9'h0FF, repeat_en=0.
  - Next cycle frame_start=1.
  - ser_out_1 = 1,0,1,0,0,1,0,1,1,0.
  - ser_out_2 = 1,1,1,1,1,1,1,1,0,0.
  - Then both lines at 0 and busy=0.
- Back-to-back: 9'h001 accepted in the final guard cycle of the previous frame. frame_start pulses exactly 10 cycles apart; ser_out_1 = 1 then nine 0s.
- Repeat: repeat_en=1, one accept of 9'h155. Line 1 repeats 1,0,1,0,1,0,1,0,1,0 for 3 frames. Drop repeat_en mid-frame 3: frame 3 completes, then IDLE.
- Handshake stall: hold in_valid=1 with changing in_data during DATA. in_ready stays 0; the transmitted bits stay equal to the originally accepted value.
- Reset mid-frame: assert rst_n=0 at bit 4. Lines go to 0 within the same cycle. After release, busy=0 and no frame starts with repeat_en=1, because held_vld is cleared.
- Parity build (SN_SERIAL_PARITY_EN): 9'h1A5 gives guard bit 1; 9'h0FF gives guard bit 0.

Source files
------------

// File: rtl/sn_operand_serializer_pkg.sv
// Shared constants and state type for the stochastic operand serializer.
package sn_operand_serializer_pkg;

    localparam int unsigned SN_DATA_W     = 9;
    localparam int unsigned SN_GUARD_BITS = 1;
    localparam int unsigned SN_FRAME_LEN  = SN_DATA_W + SN_GUARD_BITS;

    // Also used as the reset seed of the core LFSR.
    localparam logic [SN_DATA_W-1:0] SN_SEED = 9'h0B5;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StGuard
    } sn_state_e;

endpackage

// File: rtl/sn_operand_serializer_lane_shifter.sv
// One serial lane: held operand register plus the registered line output.
// Guard-bit parity is enabled by defining SN_SERIAL_PARITY_EN.
module sn_lane_shifter
    import sn_operand_serializer_pkg::*;
#(
    parameter int unsigned DATA_W     = SN_DATA_W,
    parameter int unsigned CNT_W      = 4,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  sn_state_e         state_nxt,
    input  logic [CNT_W-1:0]  cnt_nxt,
    output logic              ser_out
);

    logic [DATA_W-1:0] held_q, held_d;
    logic              ser_d;

    // The line flop is loaded from next-cycle state so a bit appears the cycle after accept.
    always_comb begin
        held_d = load ? load_data : held_q;
        ser_d  = IDLE_LEVEL;
        unique case (state_nxt)
            StData:  ser_d = held_d[cnt_nxt];
            StGuard: begin
                ser_d = 1'b0;
`ifdef SN_SERIAL_PARITY_EN
                if (cnt_nxt == CNT_W'(DATA_W)) ser_d = ^held_d;
`endif
            end
            default: ser_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q  <= '0;
            ser_out <= IDLE_LEVEL;
        end else begin
            held_q  <= held_d;
            ser_out <= ser_d;
        end
    end

endmodule

// File: rtl/sn_operand_serializer.sv
// Two-lane LSB-first operand serializer with guard bits and optional frame repeat.
// Define SN_SERIAL_PARITY_EN to carry even parity in the first guard bit.
module sn_operand_serializer
    import sn_operand_serializer_pkg::*;
#(
    parameter int unsigned DATA_W     = SN_DATA_W,
    parameter int unsigned GUARD_BITS = SN_GUARD_BITS,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              repeat_en,
    output logic              ser_out_1,
    output logic              ser_out_2,
    output logic              frame_start,
    output logic              busy
);

    localparam int unsigned FRAME_LEN = DATA_W + GUARD_BITS;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);

    sn_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_vld_q;
    logic             frame_start_d;
    logic             accept;
    logic             start;

    always_comb begin
        in_ready = (state_q == StIdle) || ((state_q == StGuard) && (cnt_q == LAST_BIT));
        accept   = in_valid && in_ready;
        start    = accept || (in_ready && repeat_en && held_vld_q);
        state_d  = state_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DATA) state_d = StGuard;
            end
            StGuard: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = start ? StData : StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        frame_start_d = (state_d == StData) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            held_vld_q  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            held_vld_q  <= held_vld_q | accept;
            frame_start <= frame_start_d;
        end
    end

    assign busy = (state_q != StIdle);

    sn_lane_shifter #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_lane_1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (in_data_1),
        .state_nxt (state_d),
        .cnt_nxt   (cnt_d),
        .ser_out   (ser_out_1)
    );

    sn_lane_shifter #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_lane_2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (in_data_2),
        .state_nxt (state_d),
        .cnt_nxt   (cnt_d),
        .ser_out   (ser_out_2)
    );

endmodule

// File: tb/tb_sn_operand_serializer.sv
// Directed bench for sn_operand_serializer; frame bits are compared against hand-derived operands.
module tb_sn_operand_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_data_1 = '0;
    logic [8:0] in_data_2 = '0;
    logic       repeat_en = 1'b0;
    logic       ser_out_1;
    logic       ser_out_2;
    logic       frame_start;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sn_operand_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data_1   (in_data_1),
        .in_data_2   (in_data_2),
        .repeat_en   (repeat_en),
        .ser_out_1   (ser_out_1),
        .ser_out_2   (ser_out_2),
        .frame_start (frame_start),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line_bit(input logic [8:0] d, input int k);
        if (k < 9) return d[k];
`ifdef SN_SERIAL_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    // Called in the bit-0 cycle of a frame; leaves off in the cycle after its final guard bit.
    task automatic run_frame(input string tag, input logic [8:0] d1, input logic [8:0] d2,
                             input bit nxt, input logic [8:0] n1, input logic [8:0] n2,
                             input bit stall, input bit rep_off);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s_fs%0d", tag, k), frame_start, (k == 0));
            check($sformatf("%s_l1_%0d", tag, k), ser_out_1, line_bit(d1, k));
            check($sformatf("%s_l2_%0d", tag, k), ser_out_2, line_bit(d2, k));
            check($sformatf("%s_rdy%0d", tag, k), in_ready, (k == 9));
            check($sformatf("%s_busy%0d", tag, k), busy, 1);
            if (k == 4 && rep_off) repeat_en = 1'b0;
            if (k < 9 && stall) begin
                in_valid  = 1'b1;
                in_data_1 = 9'($urandom);
                in_data_2 = 9'($urandom);
            end
            if (k == 9) begin
                in_valid = nxt;
                if (nxt) begin
                    in_data_1 = n1;
                    in_data_2 = n2;
                end
            end
            tick();
            if (k == 9) in_valid = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_l1"}, ser_out_1, 0);
        check({tag, "_l2"}, ser_out_2, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rdy"}, in_ready, 1);
        check({tag, "_fs"}, frame_start, 0);
    endtask

    task automatic offer(input logic [8:0] d1, input logic [8:0] d2);
        in_valid  = 1'b1;
        in_data_1 = d1;
        in_data_2 = d2;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_l1", ser_out_1, 0);
        check("rst_l2", ser_out_2, 0);
        check("rst_fs", frame_start, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check_idle("post_rst");

        offer(9'h1A5, 9'h0FF);
        run_frame("basic", 9'h1A5, 9'h0FF, 0, '0, '0, 0, 0);
        check_idle("basic_end");
        tick();
        check_idle("basic_end2");

        offer(9'h1A5, 9'h0FF);
        run_frame("b2b_a", 9'h1A5, 9'h0FF, 1, 9'h001, 9'h100, 0, 0);
        run_frame("b2b_b", 9'h001, 9'h100, 0, '0, '0, 0, 0);
        check_idle("b2b_end");

        repeat_en = 1'b1;
        offer(9'h155, 9'h0AA);
        run_frame("rep1", 9'h155, 9'h0AA, 0, '0, '0, 0, 0);
        run_frame("rep2", 9'h155, 9'h0AA, 0, '0, '0, 0, 0);
        run_frame("rep3", 9'h155, 9'h0AA, 0, '0, '0, 0, 1);
        check_idle("rep_end");

        offer(9'h0F0, 9'h10F);
        run_frame("stall", 9'h0F0, 9'h10F, 0, '0, '0, 1, 0);
        check_idle("stall_end");

        repeat_en = 1'b1;
        offer(9'h1FF, 9'h1FF);
        for (int k = 0; k < 4; k++) tick();
        check("mid_l1", ser_out_1, 1);
        check("mid_l2", ser_out_2, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_l1", ser_out_1, 0);
        check("arst_l2", ser_out_2, 0);
        check("arst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("norep_fs%0d", k), frame_start, 0);
            check($sformatf("norep_busy%0d", k), busy, 0);
            check($sformatf("norep_l1_%0d", k), ser_out_1, 0);
        end
        repeat_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
